// File: rtl/regfile_pkg.sv
// Shared defaults, types and well-known register indices for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_REG_DEPTH  = 32;

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

    // a0 (x10) carries the test-harness pass/fail flag in its lsb
    localparam int A0_IDX = 10;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: flush beats issue, issue beats write-back clear.
module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int REG_DEPTH  = 32,
    parameter int NUM_WR     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_en,
    input  logic [ADDR_WIDTH-1:0]        issue_addr,
    input  logic                         flush,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    output logic [REG_DEPTH-1:0]         busy,
    output logic [ADDR_WIDTH:0]          busy_count
);

    logic [REG_DEPTH-1:0] busy_q;
    logic [REG_DEPTH-1:0] busy_d;

    // Apply the lowest-priority rule first so later assignments override it
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                busy_d[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (issue_en && (issue_addr != '0)) begin
            busy_d[issue_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        busy_count = '0;
        for (int r = 0; r < REG_DEPTH; r++) begin
            busy_count = busy_count + {{ADDR_WIDTH{1'b0}}, busy_q[r]};
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with busy scoreboard.
// Define REGFILE_BYPASS_EN to make same-cycle write data visible on the read ports.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int REG_DEPTH  = DEF_REG_DEPTH,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
) (
    input  logic                         i_clk,
    input  logic                         i_arst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data,
    output logic [NUM_RD-1:0]            o_rd_busy,
    input  logic [NUM_WR-1:0]            i_wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] i_wr_data,
    input  logic                         i_issue_en,
    input  logic [ADDR_WIDTH-1:0]        i_issue_addr,
    input  logic                         i_flush,
    output logic [ADDR_WIDTH:0]          o_busy_count,
    output logic                         o_a0_reg_lsb
);

    logic [DATA_WIDTH-1:0] mem [REG_DEPTH];
    logic [REG_DEPTH-1:0]  busy;

    // Later ports are visited last, so the highest-index port wins a same-address conflict
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int r = 0; r < REG_DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (i_wr_en[w] && (i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                    mem[i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= i_wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_DEPTH  (REG_DEPTH),
        .NUM_WR     (NUM_WR)
    ) u_scoreboard (
        .clk        (i_clk),
        .rst        (i_arst),
        .issue_en   (i_issue_en),
        .issue_addr (i_issue_addr),
        .flush      (i_flush),
        .wr_en      (i_wr_en),
        .wr_addr    (i_wr_addr),
        .busy       (busy),
        .busy_count (o_busy_count)
    );

    always_comb begin : read_mux
        logic [ADDR_WIDTH-1:0] ra;
        ra        = '0;
        o_rd_data = '0;
        o_rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra = i_rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            o_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = mem[ra];
            o_rd_busy[p] = busy[ra];
`ifdef REGFILE_BYPASS_EN
            // A matching write makes the register ready now; a same-cycle issue only lands next cycle
            for (int w = 0; w < NUM_WR; w++) begin
                if (i_wr_en[w] && (i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ra) && (ra != '0)) begin
                    o_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = i_wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                    o_rd_busy[p] = 1'b0;
                end
            end
`else
            ra = ra;
`endif
        end
    end

    assign o_a0_reg_lsb = mem[A0_IDX][0];

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed vector table, hand sequences, random vs model.
module tb_register_file_mp;
    import regfile_pkg::*;

    logic        i_clk;
    logic        i_arst;
    logic [9:0]  i_rd_addr;
    logic [127:0] o_rd_data;
    logic [1:0]  o_rd_busy;
    logic [1:0]  i_wr_en;
    logic [9:0]  i_wr_addr;
    logic [127:0] i_wr_data;
    logic        i_issue_en;
    logic [4:0]  i_issue_addr;
    logic        i_flush;
    logic [5:0]  o_busy_count;
    logic        o_a0_reg_lsb;

    reg_addr_t ra [2];
    reg_addr_t wa [2];
    reg_data_t wd [2];

    assign i_rd_addr = {ra[1], ra[0]};
    assign i_wr_addr = {wa[1], wa[0]};
    assign i_wr_data = {wd[1], wd[0]};

    register_file_mp dut (
        .i_clk        (i_clk),
        .i_arst       (i_arst),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data    (o_rd_data),
        .o_rd_busy    (o_rd_busy),
        .i_wr_en      (i_wr_en),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .i_issue_en   (i_issue_en),
        .i_issue_addr (i_issue_addr),
        .i_flush      (i_flush),
        .o_busy_count (o_busy_count),
        .o_a0_reg_lsb (o_a0_reg_lsb)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    `ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
    `else
    localparam bit BYPASS = 1'b0;
    `endif

    // Reference state: plain array of values and a busy flag per register
    reg_data_t m_mem  [32];
    bit        m_busy [32];

    typedef struct {
        logic [1:0]  wr_en;
        reg_addr_t   wa0, wa1;
        reg_data_t   wd0, wd1;
        logic        issue_en;
        reg_addr_t   ia;
        logic        flush;
        reg_addr_t   ra0, ra1;
        reg_data_t   d0, d1;
        logic        b0, b1;
        logic [5:0]  cnt;
        logic        a0;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(logic [1:0] we, reg_addr_t a0w, reg_addr_t a1w, reg_data_t d0w, reg_data_t d1w,
                                logic ie, reg_addr_t ia, logic fl, reg_addr_t r0, reg_addr_t r1,
                                reg_data_t ed0, reg_data_t ed1, logic eb0, logic eb1, logic [5:0] ec, logic ea);
        vec_t v;
        v.wr_en = we; v.wa0 = a0w; v.wa1 = a1w; v.wd0 = d0w; v.wd1 = d1w;
        v.issue_en = ie; v.ia = ia; v.flush = fl; v.ra0 = r0; v.ra1 = r1;
        v.d0 = ed0; v.d1 = ed1; v.b0 = eb0; v.b1 = eb1; v.cnt = ec; v.a0 = ea;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] we, input reg_addr_t a0w, input reg_addr_t a1w,
                                  input reg_data_t d0w, input reg_data_t d1w,
                                  input logic ie, input reg_addr_t ia, input logic fl);
        i_wr_en = we; wa[0] = a0w; wa[1] = a1w; wd[0] = d0w; wd[1] = d1w;
        i_issue_en = ie; i_issue_addr = ia; i_flush = fl;
    endtask

    task automatic idle_inputs();
        apply_stimulus(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Expected read of one port given current model state and the inputs on the pins
    task automatic model_read(input reg_addr_t a, output reg_data_t d, output logic b);
        d = m_mem[a];
        b = m_busy[a];
        if (BYPASS) begin
            for (int w = 0; w < 2; w++) begin
                if (i_wr_en[w] && wa[w] == a && a != 0) begin
                    d = wd[w];
                    b = 1'b0;
                end
            end
        end
    endtask

    task automatic model_clock();
        bit hit [32];
        for (int r = 0; r < 32; r++) hit[r] = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (i_wr_en[w]) hit[wa[w]] = 1'b1;
            if (i_wr_en[w] && wa[w] != 0) m_mem[wa[w]] = wd[w];
        end
        for (int r = 1; r < 32; r++) begin
            if (i_flush) m_busy[r] = 1'b0;
            else if (i_issue_en && i_issue_addr == r) m_busy[r] = 1'b1;
            else if (hit[r]) m_busy[r] = 1'b0;
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    initial begin
        reg_data_t ed;
        logic      eb;

        vecs[0]  = mk(2'b01, 5, 0, 64'hDEAD_BEEF, 0, 0, 0, 0, 5, 0, 64'hDEAD_BEEF, 0, 0, 0, 0, 0);
        vecs[1]  = mk(2'b01, 0, 0, 64'h11, 0, 0, 0, 0, 0, 5, 0, 64'hDEAD_BEEF, 0, 0, 0, 0);
        vecs[2]  = mk(2'b11, 7, 7, 64'h11, 64'h22, 0, 0, 0, 7, 5, 64'h22, 64'hDEAD_BEEF, 0, 0, 0, 0);
        vecs[3]  = mk(2'b00, 0, 0, 0, 0, 1, 3, 0, 3, 7, 0, 64'h22, 1, 0, 1, 0);
        vecs[4]  = mk(2'b10, 0, 3, 0, 64'h33, 0, 0, 0, 3, 7, 64'h33, 64'h22, 0, 0, 0, 0);
        vecs[5]  = mk(2'b01, 4, 0, 64'h44, 0, 1, 4, 0, 4, 3, 64'h44, 64'h33, 1, 0, 1, 0);
        vecs[6]  = mk(2'b01, 4, 0, 64'h45, 0, 0, 0, 0, 4, 3, 64'h45, 64'h33, 0, 0, 0, 0);
        vecs[7]  = mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 4, 0, 64'h45, 0, 0, 0, 0);
        vecs[8]  = mk(2'b00, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0);
        vecs[9]  = mk(2'b00, 0, 0, 0, 0, 1, 2, 0, 2, 1, 0, 0, 1, 1, 2, 0);
        vecs[10] = mk(2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 1, 0, 0, 1, 1, 3, 0);
        vecs[11] = mk(2'b01, 10, 0, 64'h1, 0, 1, 6, 1, 6, 10, 0, 64'h1, 0, 0, 0, 1);
        vecs[12] = mk(2'b00, 0, 0, 0, 0, 1, 2, 0, 2, 10, 0, 64'h1, 1, 0, 1, 1);
        vecs[13] = mk(2'b00, 0, 0, 0, 0, 1, 2, 0, 2, 10, 0, 64'h1, 1, 0, 1, 1);
        vecs[14] = mk(2'b10, 0, 2, 0, 64'h2, 0, 0, 0, 2, 10, 64'h2, 64'h1, 0, 0, 0, 1);

        idle_inputs();
        ra[0] = 5'd5; ra[1] = 5'd7;
        i_arst = 1'b1;
        #12;
        check_output("reset_rd0", o_rd_data[63:0], 64'd0);
        check_output("reset_rd1", o_rd_data[127:64], 64'd0);
        check_output("reset_busy", {62'd0, o_rd_busy}, 64'd0);
        check_output("reset_count", {58'd0, o_busy_count}, 64'd0);
        check_output("reset_a0", {63'd0, o_a0_reg_lsb}, 64'd0);
        @(negedge i_clk);
        i_arst = 1'b0;

        // Directed table: drive a row for one edge, then check settled state with inputs idle
        for (int i = 0; i < 15; i++) begin
            @(negedge i_clk);
            apply_stimulus(vecs[i].wr_en, vecs[i].wa0, vecs[i].wa1, vecs[i].wd0, vecs[i].wd1,
                           vecs[i].issue_en, vecs[i].ia, vecs[i].flush);
            ra[0] = vecs[i].ra0; ra[1] = vecs[i].ra1;
            @(negedge i_clk);
            idle_inputs();
            #2;
            check_output($sformatf("vec%0d_rd0", i), o_rd_data[63:0], vecs[i].d0);
            check_output($sformatf("vec%0d_rd1", i), o_rd_data[127:64], vecs[i].d1);
            check_output($sformatf("vec%0d_busy0", i), {63'd0, o_rd_busy[0]}, {63'd0, vecs[i].b0});
            check_output($sformatf("vec%0d_busy1", i), {63'd0, o_rd_busy[1]}, {63'd0, vecs[i].b1});
            check_output($sformatf("vec%0d_count", i), {58'd0, o_busy_count}, {58'd0, vecs[i].cnt});
            check_output($sformatf("vec%0d_a0", i), {63'd0, o_a0_reg_lsb}, {63'd0, vecs[i].a0});
        end

        // Same-cycle read of a busy register being written back
        @(negedge i_clk);
        apply_stimulus(2'b00, 0, 0, 0, 0, 1'b1, 5'd5, 1'b0);
        ra[0] = 5'd5; ra[1] = 5'd0;
        @(negedge i_clk);
        apply_stimulus(2'b01, 5'd5, 5'd0, 64'hCAFE, 64'd0, 1'b0, 5'd0, 1'b0);
        #2;
        check_output("same_cycle_rd", o_rd_data[63:0], BYPASS ? 64'hCAFE : 64'hDEAD_BEEF);
        check_output("same_cycle_busy", {63'd0, o_rd_busy[0]}, BYPASS ? 64'd0 : 64'd1);
        check_output("x0_read_during_write", o_rd_data[127:64], 64'd0);
        @(negedge i_clk);
        idle_inputs();
        #2;
        check_output("next_cycle_rd", o_rd_data[63:0], 64'hCAFE);
        check_output("next_cycle_busy", {63'd0, o_rd_busy[0]}, 64'd0);

        // Mid-operation reset with a write in flight
        @(negedge i_clk);
        apply_stimulus(2'b00, 0, 0, 0, 0, 1'b1, 5'd8, 1'b0);
        @(negedge i_clk);
        idle_inputs();
        #2;
        check_output("pre_reset_count", {58'd0, o_busy_count}, 64'd1);
        @(negedge i_clk);
        apply_stimulus(2'b01, 5'd12, 5'd0, 64'h99, 64'd0, 1'b0, 5'd0, 1'b0);
        ra[0] = 5'd5; ra[1] = 5'd12;
        #1;
        i_arst = 1'b1;
        #1;
        check_output("arst_rd0", o_rd_data[63:0], 64'd0);
        check_output("arst_count", {58'd0, o_busy_count}, 64'd0);
        check_output("arst_a0", {63'd0, o_a0_reg_lsb}, 64'd0);
        @(negedge i_clk);
        idle_inputs();
        i_arst = 1'b0;
        #2;
        check_output("arst_dropped_write", o_rd_data[127:64], 64'd0);

        // Randomised traffic against the reference model
        model_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge i_clk);
            i_wr_en      = 2'($urandom_range(0, 3));
            wa[0]        = 5'($urandom_range(0, 15));
            wa[1]        = 5'($urandom_range(0, 15));
            wd[0]        = {$urandom, $urandom};
            wd[1]        = {$urandom, $urandom};
            i_issue_en   = 1'($urandom_range(0, 1));
            i_issue_addr = 5'($urandom_range(0, 15));
            i_flush      = ($urandom_range(0, 15) == 0);
            ra[0]        = 5'($urandom_range(0, 15));
            ra[1]        = 5'($urandom_range(0, 15));
            #2;
            for (int p = 0; p < 2; p++) begin
                model_read(ra[p], ed, eb);
                check_output($sformatf("rand%0d_rd%0d", i, p), o_rd_data[p*64 +: 64], ed);
                check_output($sformatf("rand%0d_busy%0d", i, p), {63'd0, o_rd_busy[p]}, {63'd0, eb});
            end
            check_output($sformatf("rand%0d_count", i), {58'd0, o_busy_count}, 64'(model_count()));
            check_output($sformatf("rand%0d_a0", i), {63'd0, o_a0_reg_lsb}, {63'd0, m_mem[A0_IDX][0]});
            @(posedge i_clk);
            model_clock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
